// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling via a down-counter,
// one-entry holding register with valid/ready hand-off, frame error and overrun pulses.
module uart_rx_ctrl #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx_ctrl: CLK_HZ/BAUD must be at least 4");
  end

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // Handshake: rd_data is a valid byte while rd_valid is high; the byte is consumed
  // on any rising edge where rd_valid && rd_ready. A new byte always wins over consumption.

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          rx_meta, rx_s;
  logic          tick, load, ferr_n;

  assign tick = (cnt == '0);
  assign busy = (state != S_IDLE);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    load    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = HALF_M1;
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rx_s) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DATA;
          cnt_n   = DIV_M1;
          bit_n   = 3'd0;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else begin
          shift_n = {rx_s, shift[7:1]};
          cnt_n   = DIV_M1;
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - CW'(1);
        end else if (rx_s) begin
          load    = 1'b1;
          state_n = S_IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = S_BREAK;
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so the next start needs a genuine falling edge.
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rd_data   <= 8'h00;
      rd_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      frame_err <= ferr_n;
      overrun   <= load && rd_valid && !rd_ready;
      if (load) begin
        rd_data  <= shift;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and random frame tests for uart_rx_ctrl; expectations come from bit-period arithmetic.
module tb_uart_rx_ctrl;
  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  // rx driven at negedge P is seen by the FSM at edge P+3 (two sync flops).
  localparam int SYNC   = 3;
  localparam int LOAD_OFS = SYNC + HALF + 9 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid, frame_err, overrun, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [11:0] trace [int];
  logic [7:0]  exp_q [$];

  uart_rx_ctrl #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  // clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // record outputs once per cycle, away from the active edge
  always @(negedge clk) trace[cyc] = {busy, overrun, frame_err, rd_valid, rd_data};

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tr_data(input int c);
    return int'(trace[c][7:0]);
  endfunction

  function automatic int tr_bit(input int c, input int pos);
    return int'(trace[c][pos]);
  endfunction

  function automatic int count_bit(input int pos, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) n += int'(trace[c][pos]);
    return n;
  endfunction

  // driver tasks
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int hold_low,
                            input int ready_at, input int rst_at, output int p);
    int total;
    total = 10 * DIV + hold_low;
    @(negedge clk);
    p = cyc;
    for (int rel = 0; rel < total; rel++) begin
      int j;
      if (rel != 0) @(negedge clk);
      j = rel / DIV;
      if (j == 0)      rx = 1'b0;
      else if (j <= 8) rx = b[j-1];
      else if (j == 9) rx = stop_bit;
      else             rx = 1'b0;
      if (rel == ready_at)   rd_ready = 1'b1;
      if (rel == rst_at)     rst = 1'b1;
      if (rel == rst_at + 1) rst = 1'b0;
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic glitch(input int len, output int p);
    @(negedge clk);
    rx = 1'b0;
    p = cyc;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  // a good frame loaded at p+LOAD_OFS and consumed one cycle later under rd_ready=1
  task automatic check_rx(input string tag, input int p, input logic [7:0] exp_b);
    check({tag, "_pre_valid"}, tr_bit(p + LOAD_OFS - 1, 8), 0);
    check({tag, "_valid"},     tr_bit(p + LOAD_OFS, 8), 1);
    check({tag, "_data"},      tr_data(p + LOAD_OFS), int'(exp_b));
    check({tag, "_post_valid"}, tr_bit(p + LOAD_OFS + 1, 8), 0);
    check({tag, "_ferr_cnt"},  count_bit(9, p, p + 10 * DIV - 1), 0);
  endtask

  initial begin
    int p, p1, p2, gap;
    logic [7:0] b, e;

    // reset state
    rst = 1'b1; rx = 1'b1; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", int'(rd_data), 0);
    check("rst_valid", int'(rd_valid), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(5);

    // basic frame 0x5A, rd_ready held high
    rd_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 0, -10, -10, p);
    idle(4);
    check_rx("f5a", p, 8'h5A);
    check("f5a_valid_cnt", count_bit(8, p, p + 10 * DIV + 2), 1);
    check("f5a_busy_start", tr_bit(p + SYNC, 11), 1);

    // 3-cycle glitch: START sample sees high, back to IDLE at T0+HALF
    glitch(3, p);
    idle(20);
    check("gl_busy_before", tr_bit(p + SYNC + HALF - 1, 11), 1);
    check("gl_busy_after", tr_bit(p + SYNC + HALF, 11), 0);
    check("gl_valid", count_bit(8, p, p + 20), 0);
    check("gl_ferr", count_bit(9, p, p + 20), 0);
    check("gl_busy_stays_low", count_bit(11, p + SYNC + HALF, p + 20), 0);

    // 0xFF with low stop bit, line held low 40 more cycles
    send_frame(8'hFF, 1'b0, 40, -10, -10, p);
    idle(6);
    check("brk_ferr_at", tr_bit(p + LOAD_OFS, 9), 1);
    check("brk_ferr_cnt", count_bit(9, p, p + 10 * DIV + 45), 1);
    check("brk_valid", count_bit(8, p, p + 10 * DIV + 45), 0);
    check("brk_busy_held", count_bit(11, p + SYNC, p + 10 * DIV + 40 + 2), 10 * DIV + 40);
    check("brk_busy_drop", tr_bit(p + 10 * DIV + 40 + 3, 11), 0);
    send_frame(8'h01, 1'b1, 0, -10, -10, p);
    idle(4);
    check_rx("f01", p, 8'h01);

    // overrun: two bytes with nobody accepting
    rd_ready = 1'b0;
    send_frame(8'h11, 1'b1, 0, -10, -10, p1);
    send_frame(8'h22, 1'b1, 0, -10, -10, p2);
    idle(4);
    check("ov_first_data", tr_data(p1 + LOAD_OFS), 8'h11);
    check("ov_first_valid", tr_bit(p1 + LOAD_OFS, 8), 1);
    check("ov_pulse_at", tr_bit(p2 + LOAD_OFS, 10), 1);
    check("ov_pulse_cnt", count_bit(10, p1, p2 + 10 * DIV + 2), 1);
    check("ov_data", int'(rd_data), 8'h22);
    check("ov_valid", int'(rd_valid), 1);
    check("ov_stable", tr_data(p2 + LOAD_OFS - 1), 8'h11);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
    check("ov_drained", int'(rd_valid), 0);

    // accept coincides with second load: no overrun, byte kept
    send_frame(8'h11, 1'b1, 0, -10, -10, p1);
    send_frame(8'h22, 1'b1, 0, LOAD_OFS - 1, -10, p2);
    idle(4);
    check("co_valid", tr_bit(p2 + LOAD_OFS, 8), 1);
    check("co_data", tr_data(p2 + LOAD_OFS), 8'h22);
    check("co_ovr_cnt", count_bit(10, p1, p2 + 10 * DIV + 2), 0);
    check("co_consumed", tr_bit(p2 + LOAD_OFS + 1, 8), 0);

    // reset pulse during data bit 4 (bit is high, so nothing restarts)
    rd_ready = 1'b0;
    send_frame(8'hF0, 1'b1, 0, -10, 5 * DIV + HALF, p);
    idle(4);
    check("mr_busy_before", tr_bit(p + 5 * DIV + HALF, 11), 1);
    check("mr_data", tr_data(p + 5 * DIV + HALF + 1), 0);
    check("mr_valid", tr_bit(p + 5 * DIV + HALF + 1, 8), 0);
    check("mr_ferr_cnt", count_bit(9, p, p + 10 * DIV + 2), 0);
    check("mr_ovr_cnt", count_bit(10, p, p + 10 * DIV + 2), 0);
    check("mr_idle_after", count_bit(11, p + 5 * DIV + HALF + 1, p + 10 * DIV + 2), 0);
    rd_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 0, -10, -10, p);
    idle(4);
    check_rx("fa5", p, 8'hA5);

    // random bytes with random idle gaps
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 20);
      exp_q.push_back(b);
      idle(gap);
      send_frame(b, 1'b1, 0, -10, -10, p);
      idle(4);
      e = exp_q.pop_front();
      check_rx("rnd", p, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
